// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M/RV64M multiply/divide unit for the EX stage.
// Multiply: radix-2^MUL_BITS shift-add on magnitudes, with the sign applied in FIX.
// Divide: restoring, one quotient bit per cycle, with the signs applied in FIX.
// Divide-by-zero and signed overflow (and cache hits) skip iteration: done at T+2.
// Optional feature macro: MUL_DIV_DIV_CACHE_EN adds a one-entry divide result cache.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   data1, data2      rs1 / rs2 operands, sampled on accepted start
//   MUL_DIV_start     request, accepted only when not busy (and not flushed)
//   MUL_DIV_ctrl      funct3 selecting MUL..REMU
//   MUL_DIV_flush     abort in-flight operation
//   MUL_DIV_busy      high while the FSM is not idle
//   MUL_DIV_out       result, nonzero only during MUL_DIV_done
//   MUL_DIV_done      one-cycle completion strobe
module mul_div_unit #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_BITS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic            MUL_DIV_start,
  input  logic [2:0]      MUL_DIV_ctrl,
  input  logic            MUL_DIV_flush,
  output logic            MUL_DIV_busy,
  output logic [XLEN-1:0] MUL_DIV_out,
  output logic            MUL_DIV_done
);

  localparam int unsigned N_MUL = XLEN / MUL_BITS;
  localparam int unsigned CW    = $clog2(XLEN + 1);
  localparam int unsigned PW    = 2 * XLEN;
  localparam int unsigned SW    = XLEN + MUL_BITS;
  localparam logic [XLEN-1:0] MIN_V = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

  state_e state_q, state_d;

  logic [2:0]      op_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] mcand_q;   // |multiplicand| or |divisor|
  logic [PW-1:0]   prod_q;
  logic [XLEN-1:0] quo_q, rem_q;
  logic            neg_q, rneg_q, fill_q;
  logic            busy_q, done_q;
  logic [XLEN-1:0] out_q;

  // Operand decode on the request side
  logic            is_div_c, a_sgn_c, b_sgn_c, a_neg_c, b_neg_c;
  logic [XLEN-1:0] abs_a_c, abs_b_c;
  logic            div_zero_c, ovf_c, special_c, hit_c, accept_c;

  assign is_div_c   = MUL_DIV_ctrl[2];
  assign a_sgn_c    = (MUL_DIV_ctrl == 3'b001) || (MUL_DIV_ctrl == 3'b010) ||
                      (MUL_DIV_ctrl == 3'b100) || (MUL_DIV_ctrl == 3'b110);
  assign b_sgn_c    = (MUL_DIV_ctrl == 3'b001) || (MUL_DIV_ctrl == 3'b100) ||
                      (MUL_DIV_ctrl == 3'b110);
  assign a_neg_c    = a_sgn_c && data1[XLEN-1];
  assign b_neg_c    = b_sgn_c && data2[XLEN-1];
  assign abs_a_c    = a_neg_c ? (~data1 + XLEN'(1)) : data1;
  assign abs_b_c    = b_neg_c ? (~data2 + XLEN'(1)) : data2;
  assign div_zero_c = (data2 == '0);
  assign ovf_c      = !MUL_DIV_ctrl[0] && (data1 == MIN_V) && (data2 == '1);
  assign special_c  = is_div_c && (div_zero_c || ovf_c);
  assign accept_c   = MUL_DIV_start && !MUL_DIV_flush && (state_q == S_IDLE);

  // One iteration of the multiplier: add |a| x next digit into the high half, shift right
  logic [SW-1:0]   mul_sum_c;
  logic [PW-1:0]   prod_step_c;
  assign mul_sum_c   = SW'(prod_q[PW-1:XLEN]) + SW'(mcand_q) * SW'(prod_q[MUL_BITS-1:0]);
  assign prod_step_c = {mul_sum_c, prod_q[XLEN-1:MUL_BITS]};

  // One restoring-division step; diff[XLEN] is the guard bit (set = trial went negative)
  logic [XLEN:0]   div_shift_c, div_diff_c;
  assign div_shift_c = {rem_q, quo_q[XLEN-1]};
  assign div_diff_c  = div_shift_c - {1'b0, mcand_q};

  // Sign fix-up and result selection
  logic [PW-1:0]   prod_s_c;
  logic [XLEN-1:0] quo_s_c, rem_s_c, result_c;
  assign prod_s_c = neg_q  ? (~prod_q + PW'(1))  : prod_q;
  assign quo_s_c  = neg_q  ? (~quo_q + XLEN'(1)) : quo_q;
  assign rem_s_c  = rneg_q ? (~rem_q + XLEN'(1)) : rem_q;

  always_comb begin
    result_c = '0;
    case (op_q)
      3'b000:                 result_c = prod_s_c[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result_c = prod_s_c[PW-1:XLEN];
      3'b100, 3'b101:         result_c = quo_s_c;
      default:                result_c = rem_s_c;
    endcase
  end

`ifdef MUL_DIV_DIV_CACHE_EN
  // One-entry cache of the last completed iterated divide (final signed results)
  logic            c_vld_q, c_sgn_q;
  logic [XLEN-1:0] c_a_q, c_b_q, c_quo_q, c_rem_q, pa_q, pb_q;

  assign hit_c = is_div_c && c_vld_q && (c_a_q == data1) && (c_b_q == data2) &&
                 (c_sgn_q == !MUL_DIV_ctrl[0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_vld_q <= 1'b0;
      c_sgn_q <= 1'b0;
      c_a_q   <= '0;
      c_b_q   <= '0;
      c_quo_q <= '0;
      c_rem_q <= '0;
      pa_q    <= '0;
      pb_q    <= '0;
    end else if (MUL_DIV_flush && (state_q != S_IDLE) && op_q[2]) begin
      c_vld_q <= 1'b0;
    end else begin
      if (accept_c) begin
        pa_q <= data1;
        pb_q <= data2;
      end
      if ((state_q == S_FIX) && fill_q) begin
        c_vld_q <= 1'b1;
        c_sgn_q <= !op_q[0];
        c_a_q   <= pa_q;
        c_b_q   <= pb_q;
        c_quo_q <= quo_s_c;
        c_rem_q <= rem_s_c;
      end
    end
  end
`else
  assign hit_c = 1'b0;
`endif

  // FSM next-state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (!is_div_c)              state_d = S_MUL;
          else if (special_c || hit_c) state_d = S_FIX;
          else                         state_d = S_DIV;
        end
      end
      S_MUL:  if (cnt_q == CW'(N_MUL - 1)) state_d = S_FIX;
      S_DIV:  if (cnt_q == CW'(XLEN - 1))  state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (MUL_DIV_flush && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      fill_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      if (accept_c) begin
        op_q   <= MUL_DIV_ctrl;
        cnt_q  <= '0;
        fill_q <= is_div_c && !special_c && !hit_c;
        neg_q  <= 1'b0;
        rneg_q <= 1'b0;
        if (!is_div_c) begin
          mcand_q <= abs_a_c;
          prod_q  <= {{XLEN{1'b0}}, abs_b_c};
          neg_q   <= a_neg_c ^ b_neg_c;
        end else if (div_zero_c) begin
          quo_q <= '1;
          rem_q <= data1;
        end else if (ovf_c) begin
          quo_q <= MIN_V;
          rem_q <= '0;
`ifdef MUL_DIV_DIV_CACHE_EN
        end else if (hit_c) begin
          quo_q <= c_quo_q;
          rem_q <= c_rem_q;
`endif
        end else begin
          mcand_q <= abs_b_c;
          quo_q   <= abs_a_c;
          rem_q   <= '0;
          neg_q   <= a_neg_c ^ b_neg_c;
          rneg_q  <= a_neg_c;
        end
      end else if (state_q == S_MUL) begin
        prod_q <= prod_step_c;
        cnt_q  <= cnt_q + CW'(1);
      end else if (state_q == S_DIV) begin
        rem_q  <= div_diff_c[XLEN] ? div_shift_c[XLEN-1:0] : div_diff_c[XLEN-1:0];
        quo_q  <= {quo_q[XLEN-2:0], !div_diff_c[XLEN]};
        cnt_q  <= cnt_q + CW'(1);
      end
      busy_q <= (state_d != S_IDLE);
      done_q <= (state_d == S_DONE);
      out_q  <= (state_d == S_DONE) ? result_c : '0;
    end
  end

  assign MUL_DIV_busy = busy_q;
  assign MUL_DIV_done = done_q;
  assign MUL_DIV_out  = out_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit (XLEN=32, MUL_BITS=4): the stimulus thread queues
// expected result and done cycle; a negedge monitor pops and compares on each done.
module tb_mul_div_unit;

  localparam int unsigned XLEN = 32;
`ifdef MUL_DIV_DIV_CACHE_EN
  localparam int HIT_LAT = 2;
`else
  localparam int HIT_LAT = 34;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [XLEN-1:0] data1 = '0, data2 = '0;
  logic            start = 1'b0, flush = 1'b0;
  logic [2:0]      ctrl = '0;
  logic            busy, done;
  logic [XLEN-1:0] out;

  mul_div_unit #(.XLEN(XLEN), .MUL_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .data1(data1), .data2(data2),
    .MUL_DIV_start(start), .MUL_DIV_ctrl(ctrl), .MUL_DIV_flush(flush),
    .MUL_DIV_busy(busy), .MUL_DIV_out(out), .MUL_DIV_done(done));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;

  typedef struct {
    logic [XLEN-1:0] val;
    int              cyc;
    string           name;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done must match the head of the scoreboard at the promised cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got out=%0h at cycle %0d, expected no done", out, cyc);
        end else begin
          mon_e = sb.pop_front();
          chk({mon_e.name, "_out"}, 64'(out), 64'(mon_e.val));
          chk({mon_e.name, "_cycle"}, 64'(cyc), 64'(mon_e.cyc));
        end
      end else begin
        chk("out_zero_when_not_done", 64'(out), 64'd0);
        if (sb.size() > 0 && cyc > sb[0].cyc) begin
          mon_e = sb.pop_front();
          checks++;
          errors++;
          $display("FAIL %s_missing_done: got none by cycle %0d, expected done at %0d",
                   mon_e.name, cyc, mon_e.cyc);
        end
      end
    end
  end

  // Issue one op from a negedge; checks busy each cycle and returns at negedge T+lat+1.
  // pulse: re-assert start mid-operation and in the done cycle (both must be ignored).
  task automatic run_op(input string name, input logic [2:0] c, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp,
                        input int lat, input bit pulse);
    int t;
    ctrl = c; data1 = a; data2 = b; start = 1'b1;
    t = cyc;
    sb.push_back('{exp, t + lat, name});
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (pulse && (k == 3 || k == lat)) begin
        start = 1'b1; ctrl = 3'b101; data1 = 32'd9; data2 = 32'd0;
      end
      chk({name, "_busy"}, 64'(busy), 64'(k <= lat));
    end
    start = 1'b0;
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_out", 64'(out), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mul_7x6",      3'b000, 32'd7,        32'd6,        32'h0000002A, 10, 1'b0);
    run_op("mulhu_ff",     3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 10, 1'b0);
    run_op("mulh_ff",      3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 10, 1'b0);
    run_op("mulhsu_ff",    3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 10, 1'b0);
    run_op("mul_neg",      3'b000, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 10, 1'b0);
    run_op("div_m7_2",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 1'b0);
    run_op("rem_m7_2",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, HIT_LAT, 1'b0);
    run_op("divu_by0",     3'b101, 32'd100,      32'd0,        32'hFFFFFFFF, 2, 1'b0);
    run_op("remu_by0",     3'b111, 32'd100,      32'd0,        32'd100,      2, 1'b0);
    run_op("div_ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2, 1'b0);
    run_op("rem_ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2, 1'b0);
    run_op("divu_1000_7",  3'b101, 32'd1000,     32'd7,        32'd142,      34, 1'b0);

    // Flush with start in the same cycle while a divide is in flight
    ctrl = 3'b101; data1 = 32'd50; data2 = 32'd3; start = 1'b1;
    t = cyc;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("flush_pre_busy", 64'(busy), 64'd1);
    flush = 1'b1; start = 1'b1; ctrl = 3'b000; data1 = 32'd7; data2 = 32'd6;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    chk("flush_busy_t6", 64'(busy), 64'd1 - 64'(cyc == t + 6));
    repeat (3) begin
      @(negedge clk);
      chk("flush_start_dropped", 64'(busy), 64'd0);
    end

    // Flush and start together while idle: start must be dropped
    flush = 1'b1; start = 1'b1; ctrl = 3'b000;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("idle_flush_start", 64'(busy), 64'd0);

    run_op("remu_1000_7",  3'b111, 32'd1000,     32'd7,        32'd6,        34, 1'b0);
    run_op("divu_1000_7b", 3'b101, 32'd1000,     32'd7,        32'd142,      HIT_LAT, 1'b0);

    // Asynchronous reset in the middle of a multiply
    ctrl = 3'b000; data1 = 32'd3; data2 = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_done", 64'(done), 64'd0);
    chk("rst_mid_out", 64'(out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("mul_after_rst", 3'b000, 32'd3, 32'd5, 32'd15, 10, 1'b1);
    run_op("divu_after_rst", 3'b101, 32'd1000, 32'd7, 32'd142, 34, 1'b0);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
